// File: rtl/lsu_bus_ctrl.sv
// Load/store stage: takes one memory op from execute, issues it on a single-outstanding
// valid/ready data bus, formats load data for writeback and raises misaligned/bus/timeout traps.
module lsu_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  lsu_op_i,
    input  logic [1:0]  lsu_width_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] lsu_pc_i,
    output logic        lsu_bp_o,
    output logic [31:0] lsu_pc_o,
    output logic        load_valid_o,
    output logic [31:0] wb_load_o,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic [31:0] bus_req_addr_o,
    output logic        bus_req_we_o,
    output logic [31:0] bus_req_wdata_o,
    output logic [3:0]  bus_req_strb_o,
    input  logic        bus_rsp_valid_i,
    input  logic [31:0] bus_rsp_data_i,
    input  logic        bus_rsp_err_i,
    output logic        trap_valid_o,
    output logic [3:0]  trap_cause_o,
    output logic [31:0] trap_mtval_o,
    output logic [31:0] trap_pc_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             store_q;
    logic [1:0]       width_q;
    logic             unsigned_q;
    logic [31:0]      addr_q;

    logic        is_load;
    logic        is_store;
    logic        accept;
    logic        misaligned;
    logic        timed_out;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [31:0] shifted;
    logic [31:0] load_fmt;

    assign is_load    = (lsu_op_i == 2'd1);
    assign is_store   = (lsu_op_i == 2'd2);
    assign accept     = (state == IDLE) && (is_load || is_store);
    assign misaligned = ((lsu_width_i == 2'd1) && lsu_addr_i[0]) ||
                        (lsu_width_i[1] && (lsu_addr_i[1:0] != 2'b00));
    assign timed_out  = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LIM);
    assign lsu_bp_o   = (state != IDLE);

    always_comb begin
        req_wdata = lsu_wdata_i;
        req_strb  = 4'b1111;
        case (lsu_width_i)
            2'd0: begin
                req_wdata = {4{lsu_wdata_i[7:0]}};
                req_strb  = 4'b0001 << lsu_addr_i[1:0];
            end
            2'd1: begin
                req_wdata = {2{lsu_wdata_i[15:0]}};
                req_strb  = 4'b0011 << lsu_addr_i[1:0];
            end
            default: ;
        endcase
        if (!is_store) req_strb = 4'b0000;
    end

    always_comb begin
        shifted  = bus_rsp_data_i >> {addr_q[1:0], 3'b000};
        load_fmt = shifted;
        case (width_q)
            2'd0: load_fmt = unsigned_q ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_fmt = unsigned_q ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    // Bus handshake: a request transfers in the cycle where bus_req_valid_o and
    // bus_req_ready_i are both high; request fields hold steady until then. A response
    // counts only when bus_rsp_valid_i is high while in RESP; bus_rsp_err_i is
    // meaningful only alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            store_q         <= 1'b0;
            width_q         <= 2'd0;
            unsigned_q      <= 1'b0;
            addr_q          <= 32'h0;
            lsu_pc_o        <= 32'h0;
            load_valid_o    <= 1'b0;
            wb_load_o       <= 32'h0;
            bus_req_valid_o <= 1'b0;
            bus_req_addr_o  <= 32'h0;
            bus_req_we_o    <= 1'b0;
            bus_req_wdata_o <= 32'h0;
            bus_req_strb_o  <= 4'h0;
            trap_valid_o    <= 1'b0;
            trap_cause_o    <= 4'h0;
            trap_mtval_o    <= 32'h0;
            trap_pc_o       <= 32'h0;
        end else begin
            load_valid_o <= 1'b0;
            trap_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        store_q    <= is_store;
                        width_q    <= lsu_width_i;
                        unsigned_q <= lsu_unsigned_i;
                        addr_q     <= lsu_addr_i;
                        lsu_pc_o   <= lsu_pc_i;
                        cnt        <= '0;
                        if (misaligned) begin
                            trap_valid_o <= 1'b1;
                            trap_cause_o <= is_store ? 4'd6 : 4'd4;
                            trap_mtval_o <= lsu_addr_i;
                            trap_pc_o    <= lsu_pc_i;
                        end else begin
                            state           <= REQ;
                            bus_req_valid_o <= 1'b1;
                            bus_req_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                            bus_req_we_o    <= is_store;
                            bus_req_wdata_o <= req_wdata;
                            bus_req_strb_o  <= req_strb;
                        end
                    end
                end
                REQ: begin
                    if (timed_out) begin
                        state           <= IDLE;
                        bus_req_valid_o <= 1'b0;
                        trap_valid_o    <= 1'b1;
                        trap_cause_o    <= store_q ? 4'd7 : 4'd5;
                        trap_mtval_o    <= addr_q;
                        trap_pc_o       <= lsu_pc_o;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (bus_req_ready_i) begin
                            state           <= RESP;
                            bus_req_valid_o <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    // A response arriving in the same cycle as the timeout still completes.
                    if (bus_rsp_valid_i) begin
                        state <= IDLE;
                        if (bus_rsp_err_i) begin
                            trap_valid_o <= 1'b1;
                            trap_cause_o <= store_q ? 4'd7 : 4'd5;
                            trap_mtval_o <= addr_q;
                            trap_pc_o    <= lsu_pc_o;
                        end else if (!store_q) begin
                            load_valid_o <= 1'b1;
                            wb_load_o    <= load_fmt;
                        end
                    end else if (timed_out) begin
                        state        <= IDLE;
                        trap_valid_o <= 1'b1;
                        trap_cause_o <= store_q ? 4'd7 : 4'd5;
                        trap_mtval_o <= addr_q;
                        trap_pc_o    <= lsu_pc_o;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
